// File: rtl/pci_arb_pkg.sv
// Shared types and helpers for the PCI central arbiter: FSM states and the
// round-robin winner search, sized for the largest supported master count.
package pci_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {PARK, TURN, GRANTED, BUSY} arb_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    function automatic int owner_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // First low bit of req_n at last+1, last+2, ... modulo n; last itself is checked last.
    function automatic pick_t rr_pick(input logic [MAX_MASTERS-1:0] req_n,
                                      input logic [IDX_W-1:0]       last,
                                      input int                     n);
        pick_t            p;
        int               j;
        logic [IDX_W-1:0] jj;
        p = '0;
        for (int i = MAX_MASTERS; i >= 1; i--) begin
            if (i <= n) begin
                j  = (int'(last) + i) % n;
                jj = IDX_W'(j);
                if (!req_n[jj]) begin
                    p.valid = 1'b1;
                    p.idx   = jj;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/pci_arb_timer.sv
// Grant-idle counter: counts enabled cycles up to TIMEOUT-1 and flags the
// terminal count; clear has priority over enable.
module pci_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)               cnt_q <= '0;
        else if (clr_i)            cnt_q <= '0;
        else if (en_i && !tc_o)    cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI arbiter: round-robin grants with parking, hidden arbitration
// during busy cycles, and revocation of grants left unused for TIMEOUT cycles.
module pci_arbiter
    import pci_arb_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int PARK_MASTER = 0,
    parameter int TIMEOUT     = 16
) (
    input  logic                          clk,
    input  logic                          reset_,
    input  logic [N_MASTERS-1:0]          REQ_,
    input  logic                          FRAME_,
    input  logic                          IRDY_,
    output logic [N_MASTERS-1:0]          GNT_,
    output logic [owner_w(N_MASTERS)-1:0] owner,
    output logic                          bus_busy,
    output logic                          timeout_evt
);
    localparam int               OW       = owner_w(N_MASTERS);
    localparam logic [OW-1:0]    PARK_IDX = OW'(PARK_MASTER);
    localparam logic [IDX_W-1:0] PARK_PK  = IDX_W'(PARK_MASTER);

    function automatic logic [N_MASTERS-1:0] gnt_for(input logic [OW-1:0] i);
        logic [N_MASTERS-1:0] g;
        g    = '1;
        g[i] = 1'b0;
        return g;
    endfunction

    arb_state_e             state_q;
    logic [N_MASTERS-1:0]   gnt_q;
    logic [OW-1:0]          owner_q, last_q, pend_q;
    logic                   to_park_q, busy_q, tevt_q;

    logic [MAX_MASTERS-1:0] req_pad, req_hid;
    pick_t                  pk_last, pk_own, pk_hid;
    logic                   idle, own_req, tc, drop, tmo, rearb, hid_move;

    always_comb begin
        req_pad                  = '1;
        req_pad[N_MASTERS-1:0]   = REQ_;
        req_hid                  = req_pad;
        req_hid[IDX_W'(owner_q)] = 1'b1;
        pk_last  = rr_pick(req_pad, IDX_W'(last_q), N_MASTERS);
        pk_own   = rr_pick(req_pad, IDX_W'(owner_q), N_MASTERS);
        pk_hid   = rr_pick(req_hid, IDX_W'(last_q), N_MASTERS);
        idle     = FRAME_ & IRDY_;
        own_req  = ~REQ_[owner_q];
        drop     = ~own_req & idle;
        // FRAME_ falling on the terminal-count cycle beats the timeout.
        tmo      = (state_q == GRANTED) && FRAME_ && !drop && tc;
        rearb    = ((state_q == GRANTED) && FRAME_ && (drop || tc)) ||
                   ((state_q == BUSY) && idle && !own_req);
        // Grant leaves the initiator at once; afterwards only if the new holder gives up.
        hid_move = (state_q == BUSY) && !idle && pk_hid.valid &&
                   ((owner_q == last_q) || !own_req);
    end

    pci_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .reset_ (reset_),
        .clr_i  (state_q != GRANTED),
        .en_i   (idle),
        .tc_o   (tc)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= PARK;
            gnt_q     <= gnt_for(PARK_IDX);
            owner_q   <= PARK_IDX;
            last_q    <= PARK_IDX;
            pend_q    <= PARK_IDX;
            to_park_q <= 1'b0;
            busy_q    <= 1'b0;
            tevt_q    <= 1'b0;
        end else begin
            busy_q <= ~idle;
            tevt_q <= tmo;
            if (rearb) begin
                last_q <= owner_q;
                if (!pk_own.valid && owner_q == PARK_IDX) begin
                    state_q <= PARK;
                end else begin
                    state_q   <= TURN;
                    gnt_q     <= '1;
                    pend_q    <= pk_own.valid ? OW'(pk_own.idx) : PARK_IDX;
                    to_park_q <= ~pk_own.valid;
                end
            end else begin
                case (state_q)
                    PARK: begin
                        if (!FRAME_) begin
                            state_q <= BUSY;
                            last_q  <= PARK_IDX;
                        end else if (pk_last.valid) begin
                            if (pk_last.idx == PARK_PK) begin
                                state_q <= GRANTED;
                            end else begin
                                state_q   <= TURN;
                                gnt_q     <= '1;
                                pend_q    <= OW'(pk_last.idx);
                                to_park_q <= 1'b0;
                            end
                        end
                    end
                    TURN: begin
                        gnt_q   <= gnt_for(pend_q);
                        owner_q <= pend_q;
                        state_q <= to_park_q ? PARK : GRANTED;
                    end
                    GRANTED: begin
                        if (!FRAME_) begin
                            state_q <= BUSY;
                            last_q  <= owner_q;
                        end
                    end
                    BUSY: begin
                        if (idle) begin
                            state_q <= GRANTED;
                        end else if (hid_move) begin
                            gnt_q   <= gnt_for(OW'(pk_hid.idx));
                            owner_q <= OW'(pk_hid.idx);
                        end
                    end
                    default: state_q <= PARK;
                endcase
            end
        end
    end

    assign GNT_        = gnt_q;
    assign owner       = owner_q;
    assign bus_busy    = busy_q;
    assign timeout_evt = tevt_q;

endmodule
